debug_snapshot_ctrl: RTL and testbench
======================================

Name: debug_snapshot_ctrl

Overview:
UART-driven debug controller for the pipelined datapath, replacing the fixed 55-byte debug unit. It runs the pipeline continuously or one step at a time, based on command bytes from the UART RX FIFO. At each stop point it latches a parametrised-width flat snapshot of the pipeline registers and streams it to the UART TX FIFO, then a "DONE" trailer. New relative to the previous generation: snapshot width is generic, TX backpressure is honoured, and the snapshot is captured atomically.

Parameters:
SNAP_BYTES, 55, number of snapshot bytes sent per frame (1..250)
CMD_CONT, 8'h63, ASCII 'c': run continuously
CMD_STEP, 8'h73, ASCII 's': enter step mode
CMD_NEXT, 8'h6E, ASCII 'n': advance one cycle (step mode only)
CMD_ABORT, 8'h71, ASCII 'q': return to IDLE (step mode only)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
end_of_program  in  1  pipeline reached its halt instruction
rx_data  in  8  RX FIFO head byte (first-word-fall-through)
rx_valid  in  1  RX FIFO not empty
rx_rd  out  1  one-cycle pop strobe to RX FIFO
tx_data  out  8  byte to TX FIFO
tx_wr  out  1  TX FIFO write strobe
tx_full  in  1  TX FIFO full
snapshot  in  SNAP_BYTES*8  flat pipeline state; byte k = snapshot[8k+7:8k]
pipe_enable  out  1  pipeline clock enable
pipe_reset  out  1  pipeline reset
busy  out  1  high in any state except IDLE

Behaviour:
- Reset values: state IDLE, pipe_reset=1, pipe_enable=0, rx_rd=0, tx_wr=0, tx_data=0, byte counter 0. Reset mid-frame aborts the frame immediately; no further tx_wr.
- States: IDLE, RUN, STEP_WAIT, STEP_PULSE, CAPTURE, SEND, TRAIL.
- Command pop rule:
  - In IDLE and STEP_WAIT, a cycle with rx_valid=1 asserts rx_rd for exactly one cycle. Every byte is consumed, including unknown ones.
  - rx_valid is ignored in the cycle after rx_rd, to allow for FIFO update latency.
- IDLE:
  - pipe_reset=1, pipe_enable=0.
  - CMD_CONT -> RUN. CMD_STEP -> STEP_WAIT. Other bytes are dropped and the state stays IDLE.
  - pipe_reset drops to 0 on the transition.
- RUN:
  - pipe_enable=1 every cycle.
  - When end_of_program=1: pipe_enable=0 next cycle, go to CAPTURE, mode tag = END.
- STEP_WAIT:
  - pipe_enable=0.
  - CMD_NEXT -> STEP_PULSE. CMD_ABORT -> IDLE. Others are dropped.
- STEP_PULSE:
  - pipe_enable=1 for exactly one cycle, then CAPTURE.
  - Mode tag = END if end_of_program is high in the CAPTURE cycle, otherwise STEP.
- CAPTURE:
  - Registers the whole snapshot bus into an internal SNAP_BYTES*8 buffer in one cycle; counter=0.
  - Go to SEND. The pipeline is frozen from here until the frame completes.
- SEND:
  - While tx_full=0: tx_wr=1, tx_data = buffer byte[counter], counter increments, byte 0 first.
  - While tx_full=1: tx_wr=0 and the counter holds; no byte is lost or duplicated.
  - After byte SNAP_BYTES-1 -> TRAIL with counter=0.
- TRAIL:
  - Sends 8'h44, 8'h4F, 8'h4E, 8'h45 ("DONE") under the same tx_full rule.
  - Then: mode END -> IDLE; mode STEP -> STEP_WAIT.
- Counter width: $clog2(SNAP_BYTES+1). Exactly SNAP_BYTES+4 tx_wr pulses per frame, one byte per clock at most.
- tx_data holds its last value when tx_wr=0.
- end_of_program is ignored outside RUN and the STEP_PULSE/CAPTURE check.
- busy=1 whenever state != IDLE.

Optional Feature:
DBG_FRAME_SEQ_EN:
- Defined: each frame is preceded by one sequence byte, sent in SEND before snapshot byte 0. It starts at 0 after reset, increments after each completed frame, and wraps 255->0. A frame is SNAP_BYTES+5 bytes.
- Undefined: no sequence byte; SNAP_BYTES+4 bytes per frame; no counter register exists.

Decomposition:
- Package debug_pkg holds:
  - state enum;
  - default command byte constants;
  - the trailer byte array DBG_TRAILER[4];
  - the mode tag enum (STEP/END).
- One sub-module, dbg_tx_serializer: takes a start pulse, parallel buffer and length; drives tx_wr/tx_data under tx_full; returns a done pulse. It is reused for snapshot and trailer.

Test Plan:
- SNAP_BYTES=4, snapshot=32'hA1B2C3D4, send 'c', assert end_of_program after 10 cycles -> pipe_enable high 10 cycles, then TX stream D4 C3 B2 A1 44 4F 4E 45, state IDLE, pipe_reset=1.
- Send 's','n','n' -> exactly two single-cycle pipe_enable pulses; two 8-byte frames; STEP_WAIT after each; then 'q' -> IDLE.
- Hold tx_full=1 for 5 cycles mid-frame after byte 2 -> no tx_wr during the stall; byte sequence identical to the unstalled case.
- Send 'x' in IDLE and 'z' in STEP_WAIT -> each popped with one rx_rd pulse, no state change, no TX output.
- Assert reset during TRAIL byte 1 -> tx_wr=0 next cycle, IDLE, pipe_reset=1; a following 'c' runs normally.
- With DBG_FRAME_SEQ_EN, run 257 step frames -> first byte of frames 0, 255, 256 is 00, FF, 00 respectively.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared types and constants for the UART debug snapshot controller.
// The trailer bytes spell "DONE" and close every snapshot frame.
package debug_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        STEP_WAIT,
        STEP_PULSE,
        CAPTURE,
        SEND,
        TRAIL
    } dbg_state_e;

    typedef enum logic {
        MODE_STEP,
        MODE_END
    } dbg_mode_e;

    localparam logic [7:0] DEF_CMD_CONT  = 8'h63;
    localparam logic [7:0] DEF_CMD_STEP  = 8'h73;
    localparam logic [7:0] DEF_CMD_NEXT  = 8'h6E;
    localparam logic [7:0] DEF_CMD_ABORT = 8'h71;

    localparam int TRAILER_LEN = 4;
    localparam logic [7:0] DBG_TRAILER [TRAILER_LEN] = '{8'h44, 8'h4F, 8'h4E, 8'h45};

    // Trailer packed with byte k at [8k+7:8k], matching the serializer buffer layout.
    function automatic logic [8*TRAILER_LEN-1:0] trailer_flat();
        logic [8*TRAILER_LEN-1:0] flat;
        flat = '0;
        for (int k = 0; k < TRAILER_LEN; k++) begin
            flat[k*8 +: 8] = DBG_TRAILER[k];
        end
        return flat;
    endfunction

endpackage

// File: rtl/dbg_tx_serializer.sv
// Streams bytes 0..len-1 of a flat buffer into the TX FIFO, one per clock while not full.
// A one-cycle done pulse accompanies the write of the final byte.
module dbg_tx_serializer #(
    parameter int BUF_BYTES = 4,
    parameter int CNT_W     = $clog2(BUF_BYTES + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [BUF_BYTES*8-1:0] buf_data,
    input  logic [CNT_W-1:0]       len,
    input  logic                   tx_full,
    output logic                   tx_wr,
    output logic [7:0]             tx_data,
    output logic                   done
);

    logic             active_q, active_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       last_q, last_d;
    logic [7:0]       cur_byte;
    logic             wr_fire;

    always_comb begin
        cur_byte = '0;
        for (int k = 0; k < BUF_BYTES; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                cur_byte = buf_data[k*8 +: 8];
            end
        end
    end

    assign wr_fire = active_q && !tx_full;
    assign done    = wr_fire && (cnt_q == len - CNT_W'(1));

    // A start arriving with done lets the next segment follow without a gap.
    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        if (wr_fire) begin
            last_d = cur_byte;
            cnt_d  = cnt_q + CNT_W'(1);
            if (done) begin
                active_d = 1'b0;
            end
        end
        if (start) begin
            active_d = 1'b1;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            last_q   <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
        end
    end

    assign tx_wr   = wr_fire;
    assign tx_data = wr_fire ? cur_byte : last_q;

endmodule

// File: rtl/debug_snapshot_ctrl.sv
// UART-driven run/step debug controller that streams an atomic pipeline snapshot plus "DONE".
// Define DBG_FRAME_SEQ_EN to prefix each frame with a wrapping 8-bit sequence byte.
module debug_snapshot_ctrl
    import debug_pkg::*;
#(
    parameter int         SNAP_BYTES = 55,
    parameter logic [7:0] CMD_CONT   = DEF_CMD_CONT,
    parameter logic [7:0] CMD_STEP   = DEF_CMD_STEP,
    parameter logic [7:0] CMD_NEXT   = DEF_CMD_NEXT,
    parameter logic [7:0] CMD_ABORT  = DEF_CMD_ABORT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    end_of_program,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    rx_rd,
    output logic [7:0]              tx_data,
    output logic                    tx_wr,
    input  logic                    tx_full,
    input  logic [SNAP_BYTES*8-1:0] snapshot,
    output logic                    pipe_enable,
    output logic                    pipe_reset,
    output logic                    busy
);

`ifdef DBG_FRAME_SEQ_EN
    localparam int SEQ_BYTES = 1;
`else
    localparam int SEQ_BYTES = 0;
`endif
    localparam int SEND_BYTES = SNAP_BYTES + SEQ_BYTES;
    localparam int BUF_BYTES  = (SEND_BYTES > TRAILER_LEN) ? SEND_BYTES : TRAILER_LEN;
    localparam int CNT_W      = $clog2(BUF_BYTES + 1);

    dbg_state_e              state_q, state_d;
    dbg_mode_e               mode_q, mode_d;
    logic                    rx_rd_q, rx_rd_d;
    logic                    rx_hold_q;
    logic                    pipe_enable_q, pipe_enable_d;
    logic                    pipe_reset_q, pipe_reset_d;
    logic [SNAP_BYTES*8-1:0] snap_buf_q, snap_buf_d;
    logic [SEND_BYTES*8-1:0] send_flat;
    logic                    pop_ok;

    logic                    ser_start;
    logic                    ser_done;
    logic [BUF_BYTES*8-1:0]  ser_buf;
    logic [CNT_W-1:0]        ser_len;

`ifdef DBG_FRAME_SEQ_EN
    logic [7:0] seq_q, seq_d;

    always_comb begin
        seq_d = seq_q;
        if (state_q == TRAIL && ser_done) begin
            seq_d = seq_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            seq_q <= '0;
        end else begin
            seq_q <= seq_d;
        end
    end

    assign send_flat = {snap_buf_q, seq_q};
`else
    assign send_flat = snap_buf_q;
`endif

    // A popped byte is decoded while rx_rd is high; the following cycle is skipped for FIFO latency.
    assign pop_ok = rx_valid && !rx_rd_q && !rx_hold_q;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        rx_rd_d    = 1'b0;
        snap_buf_d = snap_buf_q;
        ser_start  = 1'b0;
        case (state_q)
            IDLE: begin
                rx_rd_d = pop_ok;
                if (rx_rd_q) begin
                    if (rx_data == CMD_CONT) begin
                        state_d = RUN;
                    end else if (rx_data == CMD_STEP) begin
                        state_d = STEP_WAIT;
                    end
                end
            end
            RUN: begin
                if (end_of_program) begin
                    state_d = CAPTURE;
                    mode_d  = MODE_END;
                end
            end
            STEP_WAIT: begin
                rx_rd_d = pop_ok;
                if (rx_rd_q) begin
                    if (rx_data == CMD_NEXT) begin
                        state_d = STEP_PULSE;
                    end else if (rx_data == CMD_ABORT) begin
                        state_d = IDLE;
                    end
                end
            end
            STEP_PULSE: begin
                state_d = CAPTURE;
                mode_d  = MODE_STEP;
            end
            CAPTURE: begin
                snap_buf_d = snapshot;
                if (end_of_program) begin
                    mode_d = MODE_END;
                end
                ser_start = 1'b1;
                state_d   = SEND;
            end
            SEND: begin
                if (ser_done) begin
                    ser_start = 1'b1;
                    state_d   = TRAIL;
                end
            end
            TRAIL: begin
                if (ser_done) begin
                    state_d = (mode_q == MODE_END) ? IDLE : STEP_WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        pipe_enable_d = (state_d == RUN) || (state_d == STEP_PULSE);
        pipe_reset_d  = (state_d == IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            mode_q        <= MODE_STEP;
            rx_rd_q       <= 1'b0;
            rx_hold_q     <= 1'b0;
            pipe_enable_q <= 1'b0;
            pipe_reset_q  <= 1'b1;
            snap_buf_q    <= '0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            rx_rd_q       <= rx_rd_d;
            rx_hold_q     <= rx_rd_q;
            pipe_enable_q <= pipe_enable_d;
            pipe_reset_q  <= pipe_reset_d;
            snap_buf_q    <= snap_buf_d;
        end
    end

    always_comb begin
        ser_buf = '0;
        if (state_q == TRAIL) begin
            ser_buf[8*TRAILER_LEN-1:0] = trailer_flat();
            ser_len                    = CNT_W'(TRAILER_LEN);
        end else begin
            ser_buf[SEND_BYTES*8-1:0] = send_flat;
            ser_len                   = CNT_W'(SEND_BYTES);
        end
    end

    dbg_tx_serializer #(
        .BUF_BYTES (BUF_BYTES),
        .CNT_W     (CNT_W)
    ) u_serializer (
        .clock    (clock),
        .reset    (reset),
        .start    (ser_start),
        .buf_data (ser_buf),
        .len      (ser_len),
        .tx_full  (tx_full),
        .tx_wr    (tx_wr),
        .tx_data  (tx_data),
        .done     (ser_done)
    );

    assign rx_rd       = rx_rd_q;
    assign pipe_enable = pipe_enable_q;
    assign pipe_reset  = pipe_reset_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_debug_snapshot_ctrl.sv
// Scoreboard bench for debug_snapshot_ctrl: expected TX bytes are queued, a monitor pops and compares.
module tb_debug_snapshot_ctrl;
    import debug_pkg::*;

    localparam int SNAP_BYTES = 4;
`ifdef DBG_FRAME_SEQ_EN
    localparam int SEQ = 1;
`else
    localparam int SEQ = 0;
`endif
    localparam int FRAME = SNAP_BYTES + 4 + SEQ;

    logic                    clock;
    logic                    reset;
    logic                    end_of_program;
    logic [7:0]              rx_data;
    logic                    rx_valid;
    logic                    rx_rd;
    logic [7:0]              tx_data;
    logic                    tx_wr;
    logic                    tx_full;
    logic [SNAP_BYTES*8-1:0] snapshot;
    logic                    pipe_enable;
    logic                    pipe_reset;
    logic                    busy;

    debug_snapshot_ctrl #(.SNAP_BYTES(SNAP_BYTES)) dut (
        .clock          (clock),
        .reset          (reset),
        .end_of_program (end_of_program),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_rd          (rx_rd),
        .tx_data        (tx_data),
        .tx_wr          (tx_wr),
        .tx_full        (tx_full),
        .snapshot       (snapshot),
        .pipe_enable    (pipe_enable),
        .pipe_reset     (pipe_reset),
        .busy           (busy)
    );

    int         checks = 0;
    int         fails = 0;
    int         tx_cnt = 0;
    int         rd_cnt = 0;
    int         pe_cycles = 0;
    int         pe_rises = 0;
    logic       pe_prev = 1'b0;
    logic [7:0] exp_q [$];
    logic [7:0] rxq [$];
    logic [7:0] exp_seq = 8'h00;
    logic [7:0] trl [4] = '{8'h44, 8'h4F, 8'h4E, 8'h45};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: every TX write pops one expected byte.
    initial begin
        forever begin
            @(negedge clock);
            if (tx_wr) begin
                tx_cnt++;
                checkOutput("tx_expected_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    checkOutput("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
                end
            end
            if (tx_full) begin
                checkOutput("stall_no_wr", 32'(tx_wr), 32'd0);
            end
            if (rx_rd) rd_cnt++;
            if (pipe_enable) pe_cycles++;
            if (pipe_enable && !pe_prev) pe_rises++;
            pe_prev = pipe_enable;
        end
    end

    // First-word-fall-through RX FIFO model: pop lands just after the edge ending an rx_rd cycle.
    initial begin
        logic pend;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        forever begin
            @(negedge clock);
            pend = rx_rd;
            @(posedge clock);
            #1;
            if (pend && rxq.size() != 0) void'(rxq.pop_front());
            rx_valid = (rxq.size() != 0);
            rx_data  = (rxq.size() != 0) ? rxq[0] : 8'h00;
        end
    end

    initial begin
        #3000000;
        $display("[TB] FAIL global_timeout: got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic applyStimulus(input logic [7:0] cmd);
        rxq.push_back(cmd);
    endtask

    task automatic expectFrame(input int ntrail);
`ifdef DBG_FRAME_SEQ_EN
        exp_q.push_back(exp_seq);
`endif
        for (int k = 0; k < SNAP_BYTES; k++) exp_q.push_back(snapshot[k*8 +: 8]);
        for (int k = 0; k < ntrail; k++) exp_q.push_back(trl[k]);
        if (ntrail == 4) exp_seq = exp_seq + 8'd1;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic waitTx(input int target, input string name);
        int g;
        g = 0;
        while (tx_cnt < target && g < 400) begin
            @(posedge clock);
            #1;
            g++;
        end
        checkOutput(name, 32'(tx_cnt), 32'(target));
    endtask

    task automatic runFor(input int n);
        int k;
        int g;
        k = 0;
        g = 0;
        while (k < n && g < 200) begin
            @(negedge clock);
            g++;
            if (pipe_enable) k++;
        end
        checkOutput("run_cycles_reached", 32'(k), 32'(n));
        end_of_program = 1'b1;
        @(posedge clock);
        #1;
        end_of_program = 1'b0;
    endtask

    task automatic checkState(input string name, input dbg_state_e st);
        checkOutput(name, 32'(dut.state_q), 32'(st));
    endtask

    initial begin
        int base;
        int pe_base;
        int rise_base;
        int rd_base;
        reset          = 1'b1;
        end_of_program = 1'b0;
        tx_full        = 1'b0;
        snapshot       = 32'hA1B2C3D4;
        waitCycles(3);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_pipe_reset", 32'(pipe_reset), 32'd1);
        checkOutput("reset_pipe_enable", 32'(pipe_enable), 32'd0);
        checkOutput("reset_tx_wr", 32'(tx_wr), 32'd0);
        checkOutput("reset_rx_rd", 32'(rx_rd), 32'd0);
        checkOutput("reset_tx_data", 32'(tx_data), 32'd0);
        reset = 1'b0;
        waitCycles(2);

        $display("[TB] continuous run");
        base    = tx_cnt;
        pe_base = pe_cycles;
        expectFrame(4);
        applyStimulus(8'h63);
        runFor(10);
        waitTx(base + FRAME, "run_frame_len");
        waitCycles(4);
        checkOutput("run_pe_cycles", 32'(pe_cycles - pe_base), 32'd10);
        checkOutput("run_end_busy", 32'(busy), 32'd0);
        checkOutput("run_end_pipe_reset", 32'(pipe_reset), 32'd1);
        checkState("run_end_state", IDLE);
        checkOutput("run_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] step mode");
        snapshot  = 32'h0F1E2D3C;
        pe_base   = pe_cycles;
        rise_base = pe_rises;
        applyStimulus(8'h73);
        waitCycles(6);
        checkState("step_enter_state", STEP_WAIT);
        checkOutput("step_pipe_reset", 32'(pipe_reset), 32'd0);
        checkOutput("step_busy", 32'(busy), 32'd1);
        for (int f = 0; f < 2; f++) begin
            base = tx_cnt;
            expectFrame(4);
            applyStimulus(8'h6E);
            waitTx(base + FRAME, "step_frame_len");
            waitCycles(4);
            checkState("step_after_frame", STEP_WAIT);
        end
        checkOutput("step_pe_cycles", 32'(pe_cycles - pe_base), 32'd2);
        checkOutput("step_pe_pulses", 32'(pe_rises - rise_base), 32'd2);

        $display("[TB] backpressure");
        snapshot = 32'h55667788;
        base     = tx_cnt;
        expectFrame(4);
        applyStimulus(8'h6E);
        waitTx(base + SEQ + 3, "stall_reach_byte2");
        tx_full = 1'b1;
        waitCycles(5);
        checkOutput("stall_count_held", 32'(tx_cnt), 32'(base + SEQ + 3));
        tx_full = 1'b0;
        waitTx(base + FRAME, "stall_frame_len");
        waitCycles(4);
        checkState("stall_after_frame", STEP_WAIT);

        $display("[TB] unknown commands");
        base    = tx_cnt;
        rd_base = rd_cnt;
        applyStimulus(8'h7A);
        waitCycles(6);
        checkOutput("unk_step_rd", 32'(rd_cnt - rd_base), 32'd1);
        checkState("unk_step_state", STEP_WAIT);
        applyStimulus(8'h71);
        waitCycles(6);
        checkState("abort_state", IDLE);
        checkOutput("abort_pipe_reset", 32'(pipe_reset), 32'd1);
        rd_base = rd_cnt;
        applyStimulus(8'h78);
        waitCycles(6);
        checkOutput("unk_idle_rd", 32'(rd_cnt - rd_base), 32'd1);
        checkState("unk_idle_state", IDLE);
        checkOutput("unk_no_tx", 32'(tx_cnt), 32'(base));

        $display("[TB] reset mid-trailer");
        snapshot = 32'h13579BDF;
        base     = tx_cnt;
        expectFrame(2);
        applyStimulus(8'h63);
        runFor(3);
        waitTx(base + SEQ + SNAP_BYTES + 1, "rst_reach_trail1");
        reset = 1'b1;
        waitCycles(1);
        checkOutput("rst_tx_wr", 32'(tx_wr), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_pipe_reset", 32'(pipe_reset), 32'd1);
        reset   = 1'b0;
        exp_seq = 8'h00;
        waitCycles(5);
        checkOutput("rst_tx_stopped", 32'(tx_cnt), 32'(base + SEQ + SNAP_BYTES + 2));
        checkOutput("rst_sb_empty", 32'(exp_q.size()), 32'd0);
        base = tx_cnt;
        expectFrame(4);
        applyStimulus(8'h63);
        runFor(5);
        waitTx(base + FRAME, "rst_rerun_len");
        waitCycles(4);
        checkState("rst_rerun_state", IDLE);

`ifdef DBG_FRAME_SEQ_EN
        $display("[TB] sequence wrap");
        reset = 1'b1;
        waitCycles(2);
        reset   = 1'b0;
        exp_seq = 8'h00;
        waitCycles(2);
        applyStimulus(8'h73);
        waitCycles(6);
        for (int f = 0; f < 257; f++) begin
            snapshot = 32'(f * 32'h01010101);
            base     = tx_cnt;
            expectFrame(4);
            applyStimulus(8'h6E);
            waitTx(base + FRAME, "seq_frame_len");
            waitCycles(3);
        end
        applyStimulus(8'h71);
        waitCycles(6);
        checkState("seq_end_state", IDLE);
        checkOutput("seq_sb_empty", 32'(exp_q.size()), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
